// File: rtl/key_debounce.sv
// Debounces 5 buttons + 16 switches (2-flop sync, shared tick, per-bit run counter); sticky flags need KEY_DEBOUNCE_STICKY_EN.
// Latency: 2 sync cycles + STABLE_N ticks to outputs, press pulse one cycle after btn_o rises; no backpressure.
module key_debounce #(
    parameter int TICK_DIV = 100000,
    parameter int STABLE_N = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  btn_i,
    input  logic [15:0] sw_i,
    input  logic [4:0]  clr_sticky_i,
    output logic [4:0]  btn_o,
    output logic [15:0] sw_o,
    output logic [4:0]  btn_press_o,
    output logic [4:0]  btn_sticky_o
);
    localparam int            NB        = 21;
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    CNT_LAST  = 4'(STABLE_N - 1);

    logic [NB-1:0] meta_q, meta_d;
    logic [NB-1:0] sync_q, sync_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic [3:0]    cnt_q [NB];
    logic [3:0]    cnt_d [NB];
    logic [NB-1:0] filt_q, filt_d;
    logic [4:0]    btn_prev_q, btn_prev_d;
    logic [4:0]    press_q, press_d;

    always_comb begin
        meta_d = {sw_i, btn_i};
        sync_d = meta_q;
        tick   = (pre_q == TICK_LAST);
        pre_d  = tick ? '0 : pre_q + PW'(1);
        filt_d = filt_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                // Any agreeing sample restarts the run, so glitches never accumulate.
                if (sync_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        filt_d[i] = sync_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
        btn_prev_d = filt_q[4:0];
        press_d    = filt_q[4:0] & ~btn_prev_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q     <= '0;
            sync_q     <= '0;
            pre_q      <= '0;
            filt_q     <= '0;
            btn_prev_q <= '0;
            press_q    <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            pre_q      <= pre_d;
            filt_q     <= filt_d;
            btn_prev_q <= btn_prev_d;
            press_q    <= press_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_o       = filt_q[4:0];
    assign sw_o        = filt_q[20:5];
    assign btn_press_o = press_q;

`ifdef KEY_DEBOUNCE_STICKY_EN
    logic [4:0] sticky_q, sticky_d;

    // A press in the same cycle as a clear keeps the flag set.
    always_comb sticky_d = press_q | (sticky_q & ~clr_sticky_i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sticky_q <= '0;
        else       sticky_q <= sticky_d;
    end

    assign btn_sticky_o = sticky_q;
`else
    logic unused_clr;
    assign unused_clr   = ^clr_sticky_i;
    assign btn_sticky_o = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed + random stimulus for key_debounce (TICK_DIV=4, STABLE_N=4) against a sample-history reference model.
module tb_key_debounce;
    localparam int TD = 4;
    localparam int SN = 4;
`ifdef KEY_DEBOUNCE_STICKY_EN
    localparam logic [4:0] STICKY_EXP = 5'b00100;
`else
    localparam logic [4:0] STICKY_EXP = 5'b00000;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  btn_i;
    logic [15:0] sw_i;
    logic [4:0]  clr_sticky_i;
    logic [4:0]  btn_o;
    logic [15:0] sw_o;
    logic [4:0]  btn_press_o;
    logic [4:0]  btn_sticky_o;

    int errors = 0;
    int checks = 0;

    key_debounce #(.TICK_DIV(TD), .STABLE_N(SN)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .btn_i        (btn_i),
        .sw_i         (sw_i),
        .clr_sticky_i (clr_sticky_i),
        .btn_o        (btn_o),
        .sw_o         (sw_o),
        .btn_press_o  (btn_press_o),
        .btn_sticky_o (btn_sticky_o)
    );

    always #5 clk = ~clk;

    // Reference model: raw history per edge, decisions taken from tick samples.
    logic [20:0] m_hist[$];
    logic [20:0] m_filt;
    logic [20:0] m_filt_last;
    logic [4:0]  m_press;
    logic [4:0]  m_sticky;
    int          m_run[21];
    int          m_edge;

    task automatic model_reset();
        m_hist.delete();
        m_filt      = '0;
        m_filt_last = '0;
        m_press     = '0;
        m_sticky    = '0;
        m_edge      = 0;
        for (int i = 0; i < 21; i++) m_run[i] = 0;
    endtask

    task automatic model_edge(input logic [20:0] raw, input logic [4:0] clr);
        logic [20:0] s;
        logic [4:0]  np;
        logic [4:0]  ns;
        m_edge++;
        m_hist.push_back(raw);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        s  = (m_hist.size() == 3) ? m_hist[0] : 21'd0;
        np = m_filt[4:0] & ~m_filt_last[4:0];
        ns = '0;
`ifdef KEY_DEBOUNCE_STICKY_EN
        for (int i = 0; i < 5; i++) begin
            if (m_press[i])   ns[i] = 1'b1;
            else if (clr[i])  ns[i] = 1'b0;
            else              ns[i] = m_sticky[i];
        end
`endif
        m_filt_last = m_filt;
        if (m_edge % TD == 0) begin
            for (int i = 0; i < 21; i++) begin
                if (s[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == SN) begin
                        m_filt[i] = s[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_press  = np;
        m_sticky = ns;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rstn) model_edge({sw_i, btn_i}, clr_sticky_i);
        #1;
        chk("btn_o",        32'(btn_o),        32'(m_filt[4:0]));
        chk("sw_o",         32'(sw_o),         32'(m_filt[20:5]));
        chk("btn_press_o",  32'(btn_press_o),  32'(m_press));
        chk("btn_sticky_o", 32'(btn_sticky_o), 32'(m_sticky));
    endtask

    task automatic do_reset();
        #3 rstn = 1'b0;
        #1;
        chk("rst_btn_o",  32'(btn_o),        32'd0);
        chk("rst_sw_o",   32'(sw_o),         32'd0);
        chk("rst_press",  32'(btn_press_o),  32'd0);
        chk("rst_sticky", 32'(btn_sticky_o), 32'd0);
        model_reset();
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int n;
        int hold;
        rstn         = 1'b0;
        btn_i        = '0;
        sw_i         = '0;
        clr_sticky_i = '0;
        model_reset();
        step();
        step();
        chk("reset_btn_o",  32'(btn_o),        32'd0);
        chk("reset_sw_o",   32'(sw_o),         32'd0);
        chk("reset_press",  32'(btn_press_o),  32'd0);
        chk("reset_sticky", 32'(btn_sticky_o), 32'd0);
        rstn = 1'b1;

        // Single button held from cycle 10.
        for (int k = 0; k < 9; k++) step();
        btn_i = 5'b00001;
        n = 0;
        while (btn_o[0] !== 1'b1 && n < 18) begin
            step();
            n++;
        end
        chk("req26_btn0_within_18", 32'(btn_o[0]), 32'd1);
        step();
        chk("req26_press_pulse", 32'(btn_press_o), 32'b00001);
        step();
        chk("req26_press_end", 32'(btn_press_o), 32'd0);
        btn_i = '0;
        for (int k = 0; k < 30; k++) step();
        chk("req26_release", 32'(btn_o), 32'd0);

        // Switch chatter faster than the filter window.
        for (int k = 0; k < 100; k++) begin
            if (k % 5 == 0) sw_i[3] = ~sw_i[3];
            step();
            chk("req27_sw_quiet", 32'(sw_o), 32'd0);
        end
        sw_i = '0;
        for (int k = 0; k < 10; k++) step();

        // Sticky set, persist, clear, and clear coinciding with a press.
        btn_i = 5'b00100;
        n = 0;
        while (btn_press_o[2] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("req28_press_seen", 32'(btn_press_o), 32'b00100);
        btn_i = '0;
        for (int k = 0; k < 30; k++) step();
        chk("req28_sticky_persists", 32'(btn_sticky_o), 32'(STICKY_EXP));
        clr_sticky_i = 5'b00100;
        step();
        clr_sticky_i = '0;
        chk("req28_cleared", 32'(btn_sticky_o), 32'd0);
        btn_i = 5'b00100;
        n = 0;
        while (btn_press_o[2] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("req28_press2_seen", 32'(btn_press_o), 32'b00100);
        clr_sticky_i = 5'b00100;
        step();
        clr_sticky_i = '0;
        chk("req28_set_wins", 32'(btn_sticky_o), 32'(STICKY_EXP));

        // Reset mid-count with switches held; button 2 still held too.
        sw_i = 16'hA5A5;
        for (int k = 0; k < 8; k++) step();
        do_reset();
        n = 0;
        while (sw_o !== 16'hA5A5 && n < 18) begin
            step();
            n++;
        end
        chk("req29_sw_after_reset", 32'(sw_o), 32'hA5A5);
        for (int k = 0; k < 4; k++) step();
        chk("req22_btn2_refiltered", 32'(btn_o), 32'b00100);

        // All buttons at once, then release.
        btn_i = '0;
        sw_i  = '0;
        for (int k = 0; k < 30; k++) step();
        btn_i = 5'b11111;
        n = 0;
        while (btn_press_o === 5'b00000 && n < 30) begin
            step();
            n++;
        end
        chk("req30_all_pulse", 32'(btn_press_o), 32'b11111);
        step();
        chk("req30_pulse_end", 32'(btn_press_o), 32'd0);
        btn_i = '0;
        for (int k = 0; k < 30; k++) step();
        chk("req30_btn_released", 32'(btn_o), 32'd0);

        // Random holds, glitches, clears and occasional resets.
        for (int it = 0; it < 70; it++) begin
            btn_i = 5'($urandom);
            sw_i  = 16'($urandom);
            hold  = $urandom_range(1, 40);
            for (int k = 0; k < hold; k++) begin
                clr_sticky_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
                step();
            end
            clr_sticky_i = '0;
            if (it % 25 == 24) do_reset();
        end
        btn_i = '0;
        sw_i  = '0;
        for (int k = 0; k < 30; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
